// File: rtl/spi_rom_responder.sv
//==============================================================================
// Module      : spi_rom_responder
// Description : SPI mode-0 read-only memory responder (0x03 read, optional
//               0x6B quad read when SPI_ROM_RESPONDER_QUAD_EN is defined).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_rom_responder #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic [3:0]        spi_io_out,
    output logic [3:0]        spi_io_oe,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_data
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_DATA   = 3'd4,
        S_IGNORE = 3'd5
    } state_t;

    localparam logic [7:0] CMD_READ = 8'h03;
`ifdef SPI_ROM_RESPONDER_QUAD_EN
    localparam logic [7:0] CMD_QUAD_READ = 8'h6B;
`endif

    logic [1:0]        cs_sync_q;
    logic [1:0]        sclk_sync_q;
    logic [1:0]        mosi_sync_q;
    logic              sclk_prev_q;
    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [6:0]        cmd_sr_q, cmd_sr_d;
    logic [MEM_AW-2:0] addr_sr_q, addr_sr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              rd_dly_q;
    logic [7:0]        buf_q;
    logic [7:0]        sr_out_q, sr_out_d;
    logic              load_pend_q, load_pend_d;
    logic              quad_q, quad_d;
    logic              armed_q, armed_d;

    logic              cs_s;
    logic              mosi_s;
    logic              rise;
    logic              fall;
    logic [7:0]        cmd_full;
    logic [MEM_AW-1:0] addr_full;
    logic [7:0]        next_byte;

    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign rise      = sclk_sync_q[1] & ~sclk_prev_q;
    assign fall      = ~sclk_sync_q[1] & sclk_prev_q;
    assign cmd_full  = {cmd_sr_q, mosi_s};
    assign addr_full = {addr_sr_q, mosi_s};
    // Memory data is only valid the cycle after mem_rd, so a fall landing on
    // that cycle takes it directly; later falls use the captured copy.
    assign next_byte = rd_dly_q ? mem_data : buf_q;

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            // cs_n resets to "asserted" so a transfer already underway is ignored
            cs_sync_q   <= 2'b00;
            sclk_sync_q <= 2'b00;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            state_q     <= S_IDLE;
            cnt_q       <= 5'd0;
            cmd_sr_q    <= 7'd0;
            addr_sr_q   <= '0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            rd_dly_q    <= 1'b0;
            buf_q       <= 8'd0;
            sr_out_q    <= 8'd0;
            load_pend_q <= 1'b0;
            quad_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[1];
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            addr_sr_q   <= addr_sr_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            rd_dly_q    <= mem_rd_q;
            if (rd_dly_q) begin
                buf_q <= mem_data;
            end
            sr_out_q    <= sr_out_d;
            load_pend_q <= load_pend_d;
            quad_q      <= quad_d;
            armed_q     <= armed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_sr_d    = cmd_sr_q;
        addr_sr_d   = addr_sr_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_d    = 1'b0;
        sr_out_d    = sr_out_q;
        load_pend_d = load_pend_q;
        quad_d      = quad_q;
        armed_d     = armed_q | cs_s;

        if (cs_s) begin
            state_d     = S_IDLE;
            cnt_d       = 5'd0;
            load_pend_d = 1'b0;
            quad_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d   = 5'd0;
                    state_d = armed_q ? S_CMD : S_IGNORE;
                end
                S_CMD: begin
                    if (rise) begin
                        cmd_sr_d = cmd_full[6:0];
                        cnt_d    = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = 5'd0;
                            if (cmd_full == CMD_READ) begin
                                state_d = S_ADDR;
                            end
`ifdef SPI_ROM_RESPONDER_QUAD_EN
                            else if (cmd_full == CMD_QUAD_READ) begin
                                state_d = S_ADDR;
                                quad_d  = 1'b1;
                            end
`endif
                            else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR, S_DUMMY: begin
                    if (rise && !load_pend_q) begin
                        cnt_d = cnt_q + 5'd1;
                        if (state_q == S_ADDR) begin
                            addr_sr_d = addr_full[MEM_AW-2:0];
                            if (cnt_q == 5'd23) begin
                                cnt_d      = 5'd0;
                                mem_addr_d = addr_full;
                                mem_rd_d   = 1'b1;
                                if (quad_q) begin
                                    state_d = S_DUMMY;
                                end else begin
                                    load_pend_d = 1'b1;
                                end
                            end
                        end else if (cnt_q == 5'd7) begin
                            cnt_d       = 5'd0;
                            load_pend_d = 1'b1;
                        end
                    end else if (fall && load_pend_q) begin
                        sr_out_d    = next_byte;
                        load_pend_d = 1'b0;
                        state_d     = S_DATA;
                    end
                end
                S_DATA: begin
                    if (rise) begin
                        cnt_d = cnt_q + 5'd1;
                        // Prefetch on the rise of the last bit so the next
                        // byte is ready for the very next fall.
                        if (cnt_q == (quad_q ? 5'd1 : 5'd7)) begin
                            cnt_d       = 5'd0;
                            mem_addr_d  = mem_addr_q + 1'b1;
                            mem_rd_d    = 1'b1;
                            load_pend_d = 1'b1;
                        end
                    end else if (fall) begin
                        if (load_pend_q) begin
                            sr_out_d    = next_byte;
                            load_pend_d = 1'b0;
                        end else begin
                            sr_out_d = quad_q ? {sr_out_q[3:0], 4'b0000}
                                              : {sr_out_q[6:0], 1'b0};
                        end
                    end
                end
                S_IGNORE: begin
                    cnt_d = 5'd0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        spi_io_out = 4'b0000;
        spi_io_oe  = 4'b0000;
        if (state_q == S_DATA) begin
`ifdef SPI_ROM_RESPONDER_QUAD_EN
            if (quad_q) begin
                spi_io_out = sr_out_q[7:4];
                spi_io_oe  = 4'b1111;
            end else
`endif
            begin
                spi_io_out = {2'b00, sr_out_q[7], 1'b0};
                spi_io_oe  = 4'b0010;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_rom_responder.sv
//==============================================================================
// Module      : tb_spi_rom_responder
// Description : Self-checking bench for spi_rom_responder against a memory
//               model; quad-read checks follow SPI_ROM_RESPONDER_QUAD_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_rom_responder;

    localparam int MEM_AW = 12;
    localparam int MEM_SZ = 1 << MEM_AW;
    localparam int HP     = 50;

    logic              clk      = 1'b0;
    logic              reset    = 1'b1;
    logic              spi_cs_n = 1'b1;
    logic              spi_sclk = 1'b0;
    logic              spi_mosi = 1'b0;
    logic [3:0]        spi_io_out;
    logic [3:0]        spi_io_oe;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data = 8'h00;

    logic [7:0]        mem [0:MEM_SZ-1];
    int                n_checks = 0;
    int                n_fail   = 0;
    int                rd_count = 0;
    logic [MEM_AW-1:0] rd_addrs [$];
    logic [3:0]        oe_or;
    logic [3:0]        io_or;

    always #5 clk = ~clk;

    spi_rom_responder #(.MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_cs_n   (spi_cs_n),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_io_out (spi_io_out),
        .spi_io_oe  (spi_io_oe),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data)
    );

    // Backing memory: data returned the cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd === 1'b1) begin
            mem_data <= mem[mem_addr];
            rd_count <= rd_count + 1;
            rd_addrs.push_back(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sclk_cycle(input logic mosi_bit, output logic [3:0] io, output logic [3:0] oe);
        spi_mosi = mosi_bit;
        #HP;
        io = spi_io_out;
        oe = spi_io_oe;
        spi_sclk = 1'b1;
        #HP;
        spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        logic [3:0] io, oe;
        for (int i = n - 1; i >= 0; i--) begin
            sclk_cycle(v[i], io, oe);
            oe_or |= oe;
            io_or |= io;
        end
    endtask

    task automatic rand_clocks(input int n);
        logic [3:0] io, oe;
        for (int i = 0; i < n; i++) begin
            sclk_cycle(1'($urandom), io, oe);
            oe_or |= oe;
            io_or |= io;
        end
    endtask

    task automatic end_txn();
        #HP;
        spi_cs_n = 1'b1;
        #100;
    endtask

    task automatic do_read(input logic [23:0] addr, input int nbytes);
        int         rd0;
        logic [3:0] io, oe, bad;
        logic [7:0] got, exp;
        rd0 = rd_count;
        rd_addrs.delete();
        oe_or = 4'h0;
        io_or = 4'h0;
        bad   = 4'h0;
        spi_cs_n = 1'b0;
        #HP;
        send_bits(32'h03, 8);
        send_bits({8'h00, addr}, 24);
        check("hdr_oe", 32'(oe_or), 32'h0);
        for (int b = 0; b < nbytes; b++) begin
            for (int i = 7; i >= 0; i--) begin
                sclk_cycle(1'($urandom), io, oe);
                got[i] = io[1];
                bad |= (oe ^ 4'b0010) | (io & 4'b1101);
            end
            exp = mem[(int'(addr) + b) % MEM_SZ];
            check("rd_byte", 32'(got), 32'(exp));
        end
        check("data_oe_io", 32'(bad), 32'h0);
        end_txn();
        check("oe_idle", 32'(spi_io_oe), 32'h0);
        check("rd_count", 32'(rd_count - rd0), 32'(nbytes + 1));
        check("rd_addr_n", 32'(rd_addrs.size()), 32'(nbytes + 1));
        for (int k = 0; k < rd_addrs.size() && k <= nbytes; k++) begin
            check("rd_addr", 32'(rd_addrs[k]), 32'((int'(addr) + k) % MEM_SZ));
        end
    endtask

    task automatic do_ignored(input logic [7:0] cmd, input int nclk);
        int rd0;
        rd0 = rd_count;
        oe_or = 4'h0;
        io_or = 4'h0;
        spi_cs_n = 1'b0;
        #HP;
        send_bits(32'(cmd), 8);
        rand_clocks(nclk);
        end_txn();
        check("ign_oe", 32'(oe_or), 32'h0);
        check("ign_io", 32'(io_or), 32'h0);
        check("ign_rd", 32'(rd_count - rd0), 32'h0);
    endtask

    initial begin
        logic [3:0] io, oe;
        logic [2:0] bits3;
        int         rd0;

        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'hA5;
        mem[12'h011] = 8'h3C;
        mem[12'h012] = 8'hFF;
        mem[12'h020] = 8'h5A;

        #2;
        #50;
        reset = 1'b0;
        #10;
        check("rst_oe", 32'(spi_io_oe), 32'h0);
        check("rst_io", 32'(spi_io_out), 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        check("rst_rd", 32'(mem_rd), 32'h0);
        #100;

        // Directed read of A5 3C FF
        do_read(24'h000010, 3);
        // Address wrap at the top of the window
        do_read(24'h000FFF, 2);
        // Upper address bits must be ignored
        do_read(24'hABC010, 1);

        // Unknown command then a good read
        do_ignored(8'h9F, 40);
        do_read(24'h000123, 2);

`ifndef SPI_ROM_RESPONDER_QUAD_EN
        do_ignored(8'h6B, 40);
`else
        rd0 = rd_count;
        rd_addrs.delete();
        oe_or = 4'h0;
        spi_cs_n = 1'b0;
        #HP;
        send_bits(32'h6B, 8);
        send_bits(32'h000020, 24);
        rand_clocks(8);
        check("q_dummy_oe", 32'(oe_or), 32'h0);
        sclk_cycle(1'b0, io, oe);
        check("q_nib_hi", 32'(io), 32'h5);
        check("q_oe_hi", 32'(oe), 32'hF);
        sclk_cycle(1'b0, io, oe);
        check("q_nib_lo", 32'(io), 32'hA);
        check("q_oe_lo", 32'(oe), 32'hF);
        end_txn();
        check("q_oe_idle", 32'(spi_io_oe), 32'h0);
        check("q_rd_count", 32'(rd_count - rd0), 32'h2);
        check("q_rd_addr0", 32'(rd_addrs[0]), 32'h20);
`endif

        // Abort after 3 data bits
        spi_cs_n = 1'b0;
        #HP;
        send_bits(32'h03, 8);
        send_bits(32'h000300, 24);
        for (int i = 2; i >= 0; i--) begin
            sclk_cycle(1'b1, io, oe);
            bits3[i] = io[1];
        end
        check("abort_bits", 32'(bits3), 32'(mem[12'h300][7:5]));
        #HP;
        check("abort_oe_pre", 32'(spi_io_oe), 32'h2);
        spi_cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_oe_3clk", 32'(spi_io_oe), 32'h0);
        #6;
        #100;
        do_read(24'h000400, 2);

        // Reset in the middle of the address with cs_n held low
        rd0 = rd_count;
        oe_or = 4'h0;
        io_or = 4'h0;
        spi_cs_n = 1'b0;
        #HP;
        send_bits(32'h03, 8);
        send_bits(32'h000040 >> 14, 10);
        reset = 1'b1;
        #30;
        reset = 1'b0;
        send_bits(32'h000040, 14);
        rand_clocks(24);
        check("rstmid_oe", 32'(oe_or), 32'h0);
        check("rstmid_io", 32'(io_or), 32'h0);
        check("rstmid_rd", 32'(rd_count - rd0), 32'h0);
        end_txn();
        do_read(24'h000040, 2);

        // Randomized reads
        for (int t = 0; t < 6; t++) begin
            do_read(24'($urandom), int'($urandom_range(1, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
